dmem_stream_ctrl: RTL and testbench

Stream controller directly upstream of the 128-bit data memory. It drives the memory's write-enable, address and write-data, and consumes its read data. It packs 32-bit pixel words from an input stream into 128-bit lines and writes them to consecutive addresses (FILL). It also reads consecutive lines back and serialises them onto a 32-bit output stream (DRAIN). Each transfer is started by a single command.

---
 rtl/dmem_stream_if.sv | 50 +++++
 rtl/dmem_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dmem_stream_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_stream_if
//  Brief    : Command, pixel-stream and data-memory bundle for dmem_stream_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_stream_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_len;

    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;
    logic              done;

    // Controller side
    modport master (
        input  cmd_valid, cmd_dir, cmd_base, cmd_len,
        input  s_data, s_valid, m_ready, mem_dout,
        output cmd_ready, s_ready, m_data, m_valid,
        output mem_we, mem_addr, mem_din, busy, done
    );

    // Requester / stream / memory side
    modport slave (
        output cmd_valid, cmd_dir, cmd_base, cmd_len,
        output s_data, s_valid, m_ready, mem_dout,
        input  cmd_ready, s_ready, m_data, m_valid,
        input  mem_we, mem_addr, mem_din, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/dmem_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_stream_ctrl
//  Brief    : Packs 32-bit words into 128-bit memory lines (FILL) and
//             serialises lines back out to a 32-bit stream (DRAIN).
//  Revision : 1.0  initial release
// ============================================================================
module dmem_stream_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_stream_if.master bus
);
    localparam int LANES = DATA_W / WORD_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_LATCH = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t            state_q,  state_d;
    logic [LANE_W-1:0] lane_q,   lane_d;
    logic [ADDR_W-1:0] line_q,   line_d;
    logic [ADDR_W-1:0] len_q,    len_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] din_q,    din_d;
    logic [DATA_W-1:0] unpack_q, unpack_d;
    logic              we_q,     we_d;
    logic              done_q,   done_d;
    logic [WORD_W-1:0] w_m_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            line_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            unpack_q <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            line_q   <= line_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            unpack_q <= unpack_d;
            we_q     <= we_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        line_d   = line_q;
        len_d    = len_q;
        addr_d   = addr_q;
        din_d    = din_q;
        unpack_d = unpack_q;
        we_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_base;
                    len_d   = bus.cmd_len;
                    lane_d  = '0;
                    line_d  = '0;
                    state_d = bus.cmd_dir ? S_READ : S_FILL;
                end
            end
            S_FILL: begin
                if (bus.s_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_q == LANE_W'(i)) begin
                            din_d[i*WORD_W +: WORD_W] = bus.s_data;
                        end
                    end
                    lane_d = lane_q + 1'b1;
                    // The write strobe is registered, so raise it on entry to WRITE.
                    if (lane_q == C_LAST_LANE) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (line_q == len_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    line_d  = line_q + 1'b1;
                    lane_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                unpack_d = bus.mem_dout;
                lane_d   = '0;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.m_ready) begin
                    lane_d = lane_q + 1'b1;
                    if (lane_q == C_LAST_LANE) begin
                        if (line_q == len_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            line_d  = line_q + 1'b1;
                            lane_d  = '0;
                            state_d = S_READ;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane and unpack register only move on a handshake, so m_data holds while stalled.
    always_comb begin
        w_m_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                w_m_data = unpack_q[i*WORD_W +: WORD_W];
            end
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.s_ready   = (state_q == S_FILL);
    assign bus.m_valid   = (state_q == S_DRAIN);
    assign bus.m_data    = w_m_data;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_stream_ctrl
//  Brief    : Directed, table-driven bench for dmem_stream_ctrl with a
//             registered-read 128-bit memory model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_stream_ctrl;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam int WORD_W = 32;

    logic clk = 1'b0;
    logic rst;

    dmem_stream_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W)) bus ();

    dmem_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        dir;
        logic [7:0]  base;
        logic [7:0]  len;
        logic [31:0] wbase;
        logic [31:0] wstep;
        int          gap;
        int          mtog;
        int          intrude;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        return v.wbase + v.wstep * 32'(i);
    endfunction

    function automatic logic [127:0] line_of(input vec_t v, input int j);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of(v, 4*j + k);
        return l;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int          nlines = int'(v.len) + 1;
        int          nw     = 4 * nlines;
        int          sent = 0, gap_left = 0, beats = 0, writes = 0, cyc = 0, dones = 0;
        bit          stall = 1'b0;
        bit          fin   = 1'b0;
        logic [31:0] stall_data = '0;
        logic [7:0]  ea;

        @(negedge clk);
        check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = v.dir;
        bus.cmd_base  = v.base;
        bus.cmd_len   = v.len;
        @(posedge clk);

        while (!fin && cyc < 600) begin
            @(negedge clk);
            if (bus.mem_we) begin
                ea = v.base + 8'(writes);
                check($sformatf("%s.wr_addr%0d", tag, writes), bus.mem_addr, ea);
                check($sformatf("%s.wr_data%0d", tag, writes), bus.mem_din, line_of(v, writes));
                writes++;
            end
            if (stall) begin
                check($sformatf("%s.stall_valid", tag), bus.m_valid, 1);
                check($sformatf("%s.stall_hold", tag), bus.m_data, stall_data);
                stall = 1'b0;
            end
            if (bus.done) begin
                fin = 1'b1;
                dones++;
                check({tag, ".ready_at_done"}, bus.cmd_ready, 1);
                if (v.exp_cycles >= 0) check({tag, ".cycles"}, cyc, v.exp_cycles);
            end else begin
                bus.cmd_valid = (v.intrude != 0) && bus.busy && sent >= 1 && sent < 8;
                bus.cmd_dir   = 1'b1;
                bus.cmd_base  = 8'h55;
                if (!v.dir && sent < nw) begin
                    if (gap_left > 0) begin
                        bus.s_valid = 1'b0;
                        gap_left--;
                    end else begin
                        bus.s_valid = 1'b1;
                        bus.s_data  = word_of(v, sent);
                        if (bus.s_ready) begin
                            sent++;
                            if (v.gap != 0) gap_left = (sent % 3) + 1;
                        end
                    end
                end else begin
                    bus.s_valid = 1'b0;
                end
                if (v.dir) begin
                    bus.m_ready = (v.mtog != 0) ? (cyc % 2 == 0) : 1'b1;
                    if (bus.m_valid && bus.m_ready) begin
                        check($sformatf("%s.beat%0d", tag, beats), bus.m_data, word_of(v, beats));
                        beats++;
                    end else if (bus.m_valid) begin
                        stall      = 1'b1;
                        stall_data = bus.m_data;
                    end
                end else begin
                    bus.m_ready = 1'b0;
                end
                @(posedge clk);
                cyc++;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.s_valid   = 1'b0;
        bus.m_ready   = 1'b0;
        check({tag, ".done_seen"}, fin, 1);
        check({tag, ".writes"}, writes, v.dir ? 0 : nlines);
        check({tag, ".beats"}, beats, v.dir ? nw : 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
            check($sformatf("%s.idle_busy%0d", tag, k), bus.busy, 0);
            check($sformatf("%s.idle_we%0d", tag, k), bus.mem_we, 0);
        end
        check({tag, ".done_count"}, dones, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        vec_t rv;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;

        //           dir   base   len    wbase         wstep         gap mtog intr cycles
        vecs[0] = '{1'b0, 8'h10, 8'h00, 32'h11111111, 32'h11111111, 0, 0, 0, 5};
        vecs[1] = '{1'b1, 8'h10, 8'h00, 32'h11111111, 32'h11111111, 0, 0, 0, 6};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 32'hA0000000, 32'h00000001, 0, 0, 0, 10};
        vecs[3] = '{1'b1, 8'hFF, 8'h01, 32'hA0000000, 32'h00000001, 0, 1, 0, -1};
        vecs[4] = '{1'b0, 8'h40, 8'h02, 32'hB0000000, 32'h00000001, 1, 0, 1, -1};
        vecs[5] = '{1'b1, 8'h40, 8'h02, 32'hB0000000, 32'h00000001, 0, 0, 0, 18};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.mem_we",   bus.mem_we,   0);
        check("rst.mem_addr", bus.mem_addr, 0);
        check("rst.mem_din",  bus.mem_din,  0);
        check("rst.m_data",   bus.m_data,   0);
        check("rst.m_valid",  bus.m_valid,  0);
        check("rst.s_ready",  bus.s_ready,  0);
        check("rst.busy",     bus.busy,     0);
        check("rst.done",     bus.done,     0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.cmd_ready", bus.cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        check("mem.line10", mem[8'h10], 128'h44444444_33333333_22222222_11111111);
        check("mem.lineFF", mem[8'hFF], 128'hA0000003_A0000002_A0000001_A0000000);
        check("mem.line00", mem[8'h00], 128'hA0000007_A0000006_A0000005_A0000004);

        // Abort a fill after two words, then confirm a fresh fill starts at lane 0.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 1'b0;
        bus.cmd_base  = 8'h20;
        bus.cmd_len   = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.s_valid   = 1'b1;
        bus.s_data    = 32'hDEAD0001;
        @(posedge clk);
        @(negedge clk);
        bus.s_data    = 32'hDEAD0002;
        check("abort.s_ready", bus.s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("abort.we_before", bus.mem_we, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.mem_we",    bus.mem_we,    0);
        check("abort.mem_addr",  bus.mem_addr,  0);
        check("abort.mem_din",   bus.mem_din,   0);
        check("abort.m_valid",   bus.m_valid,   0);
        check("abort.m_data",    bus.m_data,    0);
        check("abort.s_ready",   bus.s_ready,   0);
        check("abort.busy",      bus.busy,      0);
        check("abort.done",      bus.done,      0);
        check("abort.cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        check("abort.we_after", bus.mem_we, 0);

        rv = '{1'b0, 8'h21, 8'h00, 32'hC0000000, 32'h00000001, 0, 0, 0, 5};
        run_vec(rv, "refill");
        check("refill.lane0", mem[8'h21][31:0], 32'hC0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
